// File: rtl/bshift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready per stage.
// Optional carry-out port and per-stage carry registers are enabled by defining SHIFT_CARRY_EN.
module bshift_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH),
    parameter  int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d, input int sh,
                                                     input logic [2:0] op, input logic sign);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (op)
            3'b000:  res = d >> sh;
            3'b001:  res = (d >> sh) | (sign ? ~(ones >> sh) : '0);
            3'b010:  res = d << sh;
            3'b011:  res = (d >> sh) | (d << (WIDTH - sh));
            3'b100:  res = (d << sh) | (d >> (WIDTH - sh));
            default: res = d;
        endcase
        return res;
    endfunction

`ifdef SHIFT_CARRY_EN
    function automatic logic stage_carry(input logic [WIDTH-1:0] d, input int sh,
                                         input logic [2:0] op, input logic cin);
        logic [WIDTH-1:0] t;
        case (op)
            3'b000, 3'b001, 3'b011: t = d >> (sh - 1);
            3'b010, 3'b100:         t = d >> (WIDTH - sh);
            default:                t = {{(WIDTH-1){1'b0}}, cin};
        endcase
        return t[0];
    endfunction
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Only the amount bits for later stages are carried forward; the last stage keeps no control.
        localparam int REM = SHW - 1 - k;

        logic             rdy;
        logic             nxt_rdy;
        logic             v_q, v_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [TAG_W-1:0] src_tag;
        logic             src_bit;
        logic [2:0]       src_op;
        logic             src_sign;
`ifdef SHIFT_CARRY_EN
        logic             carry_q, carry_d;
        logic             src_carry;
`endif

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_tag   = in_tag;
            assign src_bit   = in_amt[0];
            assign src_op    = in_op;
            assign src_sign  = in_data[WIDTH-1];
`ifdef SHIFT_CARRY_EN
            assign src_carry = 1'b0;
`endif
        end else begin : g_src
            assign src_valid = g_stage[k-1].v_q;
            assign src_data  = g_stage[k-1].data_q;
            assign src_tag   = g_stage[k-1].tag_q;
            assign src_bit   = g_stage[k-1].g_ctl.amt_q[0];
            assign src_op    = g_stage[k-1].g_ctl.op_q;
            assign src_sign  = g_stage[k-1].g_ctl.sign_q;
`ifdef SHIFT_CARRY_EN
            assign src_carry = g_stage[k-1].carry_q;
`endif
        end

        if (k == SHW - 1) begin : g_nxt
            assign nxt_rdy = out_ready;
        end else begin : g_nxt
            assign nxt_rdy = g_stage[k+1].rdy;
        end

        assign rdy = !v_q || nxt_rdy;

        always_comb begin
            v_d    = v_q;
            data_d = data_q;
            tag_d  = tag_q;
`ifdef SHIFT_CARRY_EN
            carry_d = carry_q;
`endif
            if (rdy) begin
                v_d    = src_valid;
                data_d = src_bit ? shift_stage(src_data, 1 << k, src_op, src_sign) : src_data;
                tag_d  = src_tag;
`ifdef SHIFT_CARRY_EN
                carry_d = src_bit ? stage_carry(src_data, 1 << k, src_op, src_carry) : src_carry;
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q    <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
`ifdef SHIFT_CARRY_EN
                carry_q <= 1'b0;
`endif
            end else begin
                v_q    <= v_d;
                data_q <= data_d;
                tag_q  <= tag_d;
`ifdef SHIFT_CARRY_EN
                carry_q <= carry_d;
`endif
            end
        end

        if (REM > 0) begin : g_ctl
            logic [REM-1:0] amt_q, amt_d;
            logic [2:0]     op_q, op_d;
            logic           sign_q, sign_d;
            logic [REM-1:0] src_rest;

            if (k == 0) begin : g_rest
                assign src_rest = in_amt[SHW-1:1];
            end else begin : g_rest
                assign src_rest = g_stage[k-1].g_ctl.amt_q[REM:1];
            end

            always_comb begin
                amt_d  = amt_q;
                op_d   = op_q;
                sign_d = sign_q;
                if (rdy) begin
                    amt_d  = src_rest;
                    op_d   = src_op;
                    sign_d = src_sign;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    amt_q  <= '0;
                    op_q   <= '0;
                    sign_q <= 1'b0;
                end else begin
                    amt_q  <= amt_d;
                    op_q   <= op_d;
                    sign_q <= sign_d;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].rdy;
    assign out_valid = g_stage[SHW-1].v_q;
    assign out_data  = g_stage[SHW-1].data_q;
    assign out_tag   = g_stage[SHW-1].tag_q;
`ifdef SHIFT_CARRY_EN
    assign out_carry = g_stage[SHW-1].carry_q;
`endif

endmodule

// File: tb/tb_bshift_pipe.sv
// Self-checking bench for bshift_pipe (WIDTH=32, TAG_W=4); carry checks apply when SHIFT_CARRY_EN is defined.
module tb_bshift_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_amt = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             carry_obs;

`ifdef SHIFT_CARRY_EN
    logic out_carry;
    assign carry_obs = out_carry;
`else
    assign carry_obs = 1'b0;
`endif

    bshift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SHIFT_CARRY_EN
        .out_carry (out_carry),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        carry;
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    // Whole-amount reference: shift by a in one step, rotate via a doubled word.
    function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] d, input int a);
        logic [63:0] w;
        case (op)
            3'd0: return d >> a;
            3'd1: return $signed(d) >>> a;
            3'd2: return d << a;
            3'd3: begin w = {d, d} >> a; return w[31:0]; end
            3'd4: begin w = {d, d} << a; return w[63:32]; end
            default: return d;
        endcase
    endfunction

    function automatic logic ref_carry(input logic [2:0] op, input logic [31:0] d, input int a);
        logic [31:0] t;
        if (a == 0 || op > 3'd4) return 1'b0;
        if (op == 3'd2 || op == 3'd4) t = d >> (32 - a);
        else t = d >> (a - 1);
        return t[0];
    endfunction

    task automatic tick(input logic iv, input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                        input logic [3:0] tg, input logic ordy, output logic ir);
        rec_t r;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        ir = in_ready;
        if (iv && in_ready === 1'b1 && !reset) begin
            r.data  = ref_data(op, d, int'(a));
            r.tag   = tg;
            r.carry = ref_carry(op, d, int'(a));
            r.cyc   = cyc;
            exp_q.push_back(r);
        end
        if (out_valid === 1'b1 && ordy && !reset) begin
            r.data  = out_data;
            r.tag   = out_tag;
            r.carry = carry_obs;
            r.cyc   = cyc;
            obs_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic ir;
        reset = 1'b1;
        tick(1'b1, $urandom, 5'd3, 3'd0, 4'hA, 1'b1, ir);
        tick(1'b1, $urandom, 5'd7, 3'd2, 4'h5, 1'b1, ir);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
`ifdef SHIFT_CARRY_EN
        checks++; if (carry_obs !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_obs); end
`endif
        reset = 1'b0;
        tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", ir); end
        for (int i = 0; i < 8; i++) tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_no_accept: got %0d results expected 0", obs_q.size()); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_directed;
        logic [2:0]  t_op  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd1, 3'd3, 3'd0, 3'd2};
        logic [31:0] t_in  [10] = '{32'h80000001, 32'h80000000, 32'h00000001, 32'h00000001, 32'h80000000,
                                   32'h1234ABCD, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000010, 32'h40000000};
        logic [4:0]  t_amt [10] = '{5'd4, 5'd31, 5'd31, 5'd1, 5'd1, 5'd7, 5'd0, 5'd0, 5'd5, 5'd2};
        logic [31:0] t_exp [10] = '{32'h08000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000001,
                                   32'h1234ABCD, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 32'h00000000};
        logic        t_cry [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ir;
        int n;
        for (int i = 0; i < 10; i++) begin
            exp_q.delete();
            obs_q.delete();
            tick(1'b1, t_in[i], t_amt[i], t_op[i], 4'(i), 1'b1, ir);
            n = 0;
            while (obs_q.size() == 0 && n < 20) begin
                tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
                n++;
            end
            checks++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL directed_timeout[%0d]: got no result expected %h", i, t_exp[i]);
            end else begin
                if (obs_q[0].data !== t_exp[i]) begin
                    errors++; $display("FAIL directed_data[%0d]: got %h expected %h", i, obs_q[0].data, t_exp[i]);
                end
                checks++;
                if (obs_q[0].tag !== 4'(i)) begin
                    errors++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, obs_q[0].tag, 4'(i));
                end
                checks++;
                if (obs_q[0].cyc - exp_q[0].cyc != SHW) begin
                    errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, obs_q[0].cyc - exp_q[0].cyc, SHW);
                end
`ifdef SHIFT_CARRY_EN
                checks++;
                if (obs_q[0].carry !== t_cry[i]) begin
                    errors++; $display("FAIL directed_carry[%0d]: got %b expected %b", i, obs_q[0].carry, t_cry[i]);
                end
`endif
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int stall_left = 4;
        int guard = 0;
        bit saw_block = 0;
        logic stalled_prev = 1'b0;
        logic [31:0] held = '0;
        logic ordy, want_rdy, ir;
        exp_q.delete();
        obs_q.delete();
        while ((sent < 6 || obs_q.size() < exp_q.size()) && guard < 60) begin
            guard++;
            ordy = 1'b1;
            if (out_valid === 1'b1 && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            want_rdy = (exp_q.size() - obs_q.size() < SHW) || ordy;
            if (stalled_prev) begin
                checks++;
                if (out_data !== held) begin errors++; $display("FAIL stall_hold: got %h expected %h", out_data, held); end
            end
            stalled_prev = (out_valid === 1'b1) && !ordy;
            held = out_data;
            tick(sent < 6, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 4'(sent), ordy, ir);
            checks++;
            if (ir !== want_rdy) begin errors++; $display("FAIL b2b_in_ready: got %b expected %b", ir, want_rdy); end
            if (ir === 1'b0) saw_block = 1;
            if (sent < 6 && ir === 1'b1) sent++;
        end
        checks++; if (guard >= 60) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 6", obs_q.size()); end
        checks++; if (!saw_block) begin errors++; $display("FAIL b2b_backpressure: got in_ready always 1 expected a 0"); end
        checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== 4'(i) || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got tag %h data %h expected tag %h data %h",
                         i, obs_q[i].tag, obs_q[i].data, 4'(i), exp_q[i].data);
            end
`ifdef SHIFT_CARRY_EN
            checks++;
            if (obs_q[i].carry !== exp_q[i].carry) begin
                errors++; $display("FAIL b2b_carry[%0d]: got %b expected %b", i, obs_q[i].carry, exp_q[i].carry);
            end
`endif
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        logic ir;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'd0, 4'(i + 8), 1'b1, ir);
        reset = 1'b1;
        tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
        exp_q.delete();
        tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ir); end
        for (int i = 0; i < 10; i++) tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_stale: got %0d results expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_random;
        logic iv, ordy, want_rdy, ir;
        int n;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 300; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            want_rdy = (exp_q.size() - obs_q.size() < SHW) || ordy;
            tick(iv, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 4'($urandom), ordy, ir);
            checks++;
            if (ir !== want_rdy) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, ir, want_rdy); end
        end
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 40) begin
            tick(1'b0, '0, '0, '0, '0, 1'b1, ir);
            n++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag) begin
                errors++;
                $display("FAIL rand_result[%0d]: got tag %h data %h expected tag %h data %h",
                         i, obs_q[i].tag, obs_q[i].data, exp_q[i].tag, exp_q[i].data);
            end
`ifdef SHIFT_CARRY_EN
            checks++;
            if (obs_q[i].carry !== exp_q[i].carry) begin
                errors++; $display("FAIL rand_carry[%0d]: got %b expected %b", i, obs_q[i].carry, exp_q[i].carry);
            end
`endif
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
